// File: rtl/chunker_fifo_pkg.sv
// Shared definitions for the chunker family: chunk ordering and chunk extraction.
// The word is passed zero-extended to CHUNK_MAX_W bits; callers truncate the result to M.
package chunker_pkg;

    localparam int CHUNK_MAX_W = 256;

    typedef enum logic {
        MSB_FIRST = 1'b0,
        LSB_FIRST = 1'b1
    } chunk_order_e;

    // Returns the word shifted so that chunk idx of nr (each m bits) sits in the low bits.
    function automatic logic [CHUNK_MAX_W-1:0] chunk_sel(
        input logic [CHUNK_MAX_W-1:0] word,
        input int                     idx,
        input int                     nr,
        input int                     m,
        input chunk_order_e           order
    );
        int sh;
        sh = (order == MSB_FIRST) ? (nr - 1 - idx) * m : idx * m;
        return word >> sh;
    endfunction

endpackage

// File: rtl/chunker_fifo_if.sv
// Word-in / chunk-out bus of chunker_fifo. slave is the chunker side, master the
// producer/consumer side.
interface chunker_fifo_if #(
    parameter int L     = 8,
    parameter int M     = 4,
    parameter int DEPTH = 4
) ();
    localparam int LW = $clog2(DEPTH + 1);

    logic [L-1:0]  data_in;
    logic          strobe;
    logic          ready_in;
    logic [M-1:0]  q;
    logic          valid;
    logic          ready;
    logic          last;
    logic [LW-1:0] level;
    logic          overflow;

    modport slave (
        input  data_in, strobe, ready,
        output ready_in, q, valid, last, level, overflow
    );

    modport master (
        output data_in, strobe, ready,
        input  ready_in, q, valid, last, level, overflow
    );
endinterface

// File: rtl/chunker_fifo_word_fifo.sv
// Synchronous show-ahead FIFO: rd_data always presents the head word while not empty.
// Writes when full and reads when empty are ignored.
module word_fifo #(
    parameter int W     = 8,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       wr_en,
    input  logic [W-1:0]               wr_data,
    input  logic                       rd_en,
    output logic [W-1:0]               rd_data,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic                       full,
    output logic                       empty
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    logic [W-1:0]  r_mem [DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [CW-1:0] r_count;
    logic          w_do_wr;
    logic          w_do_rd;

    assign full    = (r_count == CW'(DEPTH));
    assign empty   = (r_count == '0);
    assign count   = r_count;
    assign w_do_wr = wr_en && !full;
    assign w_do_rd = rd_en && !empty;
    assign rd_data = r_mem[r_rd_ptr];

    // Storage is not reset; only the pointers and count define its contents.
    always_ff @(posedge clk) begin
        if (w_do_wr) begin
            r_mem[r_wr_ptr] <= wr_data;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_wr) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_do_rd) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            if (w_do_wr && !w_do_rd) begin
                r_count <= r_count + 1'b1;
            end else if (!w_do_wr && w_do_rd) begin
                r_count <= r_count - 1'b1;
            end
        end
    end
endmodule

// File: rtl/chunker_fifo.sv
// Buffers L-bit words in a DEPTH-word FIFO and emits each as L/M M-bit chunks with
// ready/valid backpressure; an empty block lets a new word fall straight through.
module chunker_fifo
    import chunker_pkg::*;
#(
    parameter int           L     = 8,
    parameter int           M     = 4,
    parameter int           DEPTH = 4,
    parameter chunk_order_e ORDER = MSB_FIRST
) (
    input  logic          clk,
    input  logic          reset,
    chunker_fifo_if.slave bus
);
    localparam int NR    = L / M;
    localparam int CNT_W = (NR > 1) ? $clog2(NR) : 1;
    localparam int LVL_W = $clog2(DEPTH + 1);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NR - 1);

    if ((M < 1) || (L < M) || ((L % M) != 0) || (L > CHUNK_MAX_W)) begin : g_bad_width
        $error("chunker_fifo: L must be a multiple of M with M <= L <= CHUNK_MAX_W");
    end
    if ((DEPTH < 2) || ((DEPTH & (DEPTH - 1)) != 0)) begin : g_bad_depth
        $error("chunker_fifo: DEPTH must be a power of two and at least 2");
    end

    logic [L-1:0]     r_word;
    logic [CNT_W-1:0] r_cnt;
    logic [M-1:0]     r_q;
    logic             r_valid;
    logic             r_last;
    logic             r_overflow;

    logic [L-1:0]     w_fifo_data;
    logic [LVL_W-1:0] w_fifo_count;
    logic             w_full;
    logic             w_empty;
    logic             w_ready_in;
    logic             w_push_req;
    logic             w_hs;
    logic             w_load;
    logic             w_pop;
    logic             w_fall;
    logic             w_wr;
    logic [L-1:0]     w_src;
    logic [CNT_W-1:0] w_next_cnt;
    logic [M-1:0]     w_first_chunk;
    logic [M-1:0]     w_next_chunk;

    assign w_ready_in = !w_full;
    assign w_push_req = bus.strobe && w_ready_in;
    assign w_hs       = r_valid && bus.ready;
    // The output register takes a new word when idle or as its last chunk is accepted.
    assign w_load     = !r_valid || (w_hs && r_last);
    assign w_pop      = w_load && !w_empty;
    assign w_fall     = w_load && w_empty && w_push_req;
    assign w_wr       = w_push_req && !w_fall;
    assign w_src      = w_empty ? bus.data_in : w_fifo_data;
    assign w_next_cnt = r_cnt + 1'b1;

    assign w_first_chunk = M'(chunk_sel(CHUNK_MAX_W'(w_src), 0, NR, M, ORDER));
    assign w_next_chunk  = M'(chunk_sel(CHUNK_MAX_W'(r_word), int'(w_next_cnt), NR, M, ORDER));

    word_fifo #(
        .W     (L),
        .DEPTH (DEPTH)
    ) u_word_fifo (
        .clk     (clk),
        .reset   (reset),
        .wr_en   (w_wr),
        .wr_data (bus.data_in),
        .rd_en   (w_pop),
        .rd_data (w_fifo_data),
        .count   (w_fifo_count),
        .full    (w_full),
        .empty   (w_empty)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_word     <= '0;
            r_cnt      <= '0;
            r_q        <= '0;
            r_valid    <= 1'b0;
            r_last     <= 1'b0;
            r_overflow <= 1'b0;
        end else begin
            if (bus.strobe && !w_ready_in) begin
                r_overflow <= 1'b1;
            end
            if (w_load) begin
                if (w_pop || w_fall) begin
                    r_word  <= w_src;
                    r_cnt   <= '0;
                    r_q     <= w_first_chunk;
                    r_valid <= 1'b1;
                    r_last  <= (NR == 1);
                end else begin
                    r_valid <= 1'b0;
                    r_last  <= 1'b0;
                end
            end else if (w_hs) begin
                r_cnt  <= w_next_cnt;
                r_q    <= w_next_chunk;
                r_last <= (w_next_cnt == LAST_CNT);
            end
        end
    end

    assign bus.ready_in = w_ready_in;
    assign bus.q        = r_q;
    assign bus.valid    = r_valid;
    assign bus.last     = r_last;
    assign bus.level    = w_fifo_count;
    assign bus.overflow = r_overflow;
endmodule

// File: tb/tb_chunker_fifo.sv
// Drives an MSB-first and an LSB-first chunker_fifo with identical stimulus and checks
// both every cycle against a queue-based word/chunk reference model.
module tb_chunker_fifo;
    import chunker_pkg::*;

    localparam int L     = 8;
    localparam int M     = 4;
    localparam int DEPTH = 4;
    localparam int NR    = L / M;

    logic         clk;
    logic         reset;
    logic [L-1:0] tb_data;
    logic         tb_strobe;
    logic         tb_ready;

    int n_checks = 0;
    int n_fail   = 0;

    chunker_fifo_if #(.L(L), .M(M), .DEPTH(DEPTH)) if_m ();
    chunker_fifo_if #(.L(L), .M(M), .DEPTH(DEPTH)) if_l ();

    assign if_m.data_in = tb_data;
    assign if_m.strobe  = tb_strobe;
    assign if_m.ready   = tb_ready;
    assign if_l.data_in = tb_data;
    assign if_l.strobe  = tb_strobe;
    assign if_l.ready   = tb_ready;

    chunker_fifo #(.L(L), .M(M), .DEPTH(DEPTH), .ORDER(MSB_FIRST)) u_dut_msb (
        .clk   (clk),
        .reset (reset),
        .bus   (if_m.slave)
    );

    chunker_fifo #(.L(L), .M(M), .DEPTH(DEPTH), .ORDER(LSB_FIRST)) u_dut_lsb (
        .clk   (clk),
        .reset (reset),
        .bus   (if_l.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: words waiting, word being emitted, index of the chunk on q.
    logic [L-1:0] m_fifo[$];
    logic [L-1:0] m_word;
    int           m_idx;
    bit           m_valid;
    bit           m_ovf;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [M-1:0] exp_chunk(input logic [L-1:0] w, input int idx, input bit msb);
        int sh;
        sh = msb ? (NR - 1 - idx) * M : idx * M;
        return M'((w >> sh) & ((1 << M) - 1));
    endfunction

    function automatic void model_reset();
        m_fifo.delete();
        m_word  = '0;
        m_idx   = 0;
        m_valid = 1'b0;
        m_ovf   = 1'b0;
    endfunction

    task automatic model_edge(input logic [L-1:0] d, input bit s, input bit r);
        bit rin;
        bit acc;
        bit fin;
        rin = (m_fifo.size() < DEPTH);
        acc = s && rin;
        fin = m_valid && r && (m_idx == NR - 1);
        if (s && !rin) m_ovf = 1'b1;
        if (acc) $display("word %02h accepted (queued %0d)", d, m_fifo.size());
        if (!m_valid || fin) begin
            if (m_fifo.size() > 0) begin
                m_word  = m_fifo.pop_front();
                m_idx   = 0;
                m_valid = 1'b1;
                if (acc) m_fifo.push_back(d);
            end else if (acc) begin
                m_word  = d;
                m_idx   = 0;
                m_valid = 1'b1;
            end else begin
                m_valid = 1'b0;
            end
        end else begin
            if (r) m_idx++;
            if (acc) m_fifo.push_back(d);
        end
    endtask

    task automatic compare_all();
        bit exp_last;
        exp_last = m_valid && (m_idx == NR - 1);
        check("msb.ready_in", 32'(if_m.ready_in), 32'(m_fifo.size() < DEPTH));
        check("msb.valid",    32'(if_m.valid),    32'(m_valid));
        check("msb.last",     32'(if_m.last),     32'(exp_last));
        check("msb.level",    32'(if_m.level),    32'(m_fifo.size()));
        check("msb.overflow", 32'(if_m.overflow), 32'(m_ovf));
        check("lsb.valid",    32'(if_l.valid),    32'(m_valid));
        check("lsb.last",     32'(if_l.last),     32'(exp_last));
        check("lsb.level",    32'(if_l.level),    32'(m_fifo.size()));
        check("lsb.overflow", 32'(if_l.overflow), 32'(m_ovf));
        if (m_valid) begin
            check("msb.q", 32'(if_m.q), 32'(exp_chunk(m_word, m_idx, 1'b1)));
            check("lsb.q", 32'(if_l.q), 32'(exp_chunk(m_word, m_idx, 1'b0)));
        end
    endtask

    task automatic step(input logic [L-1:0] d, input bit s, input bit r);
        tb_data   = d;
        tb_strobe = s;
        tb_ready  = r;
        @(posedge clk);
        model_edge(d, s, r);
        #1;
        compare_all();
    endtask

    // Asserts reset between edges, checks the asynchronous clear, releases on a falling edge.
    task automatic do_reset();
        tb_strobe = 1'b0;
        tb_ready  = 1'b0;
        reset     = 1'b0;
        #1;
        model_reset();
        check("rst.msb.valid",    32'(if_m.valid),    32'd0);
        check("rst.msb.last",     32'(if_m.last),     32'd0);
        check("rst.msb.level",    32'(if_m.level),    32'd0);
        check("rst.msb.overflow", 32'(if_m.overflow), 32'd0);
        check("rst.msb.q",        32'(if_m.q),        32'd0);
        check("rst.msb.ready_in", 32'(if_m.ready_in), 32'd1);
        check("rst.lsb.q",        32'(if_l.q),        32'd0);
        @(negedge clk);
        reset = 1'b1;
        #1;
    endtask

    initial begin
        reset     = 1'b0;
        tb_data   = '0;
        tb_strobe = 1'b0;
        tb_ready  = 1'b1;
        model_reset();
        #2;
        do_reset();

        // Single word, both orders.
        step(8'h00, 1'b0, 1'b1);
        step(8'h6B, 1'b1, 1'b1);
        check("t1.msb.q0", 32'(if_m.q), 32'h6);
        check("t1.lsb.q0", 32'(if_l.q), 32'hB);
        step(8'h00, 1'b0, 1'b1);
        check("t1.msb.q1", 32'(if_m.q), 32'hB);
        check("t1.msb.last1", 32'(if_m.last), 32'd1);
        check("t1.lsb.q1", 32'(if_l.q), 32'h6);
        step(8'h00, 1'b0, 1'b1);
        check("t1.valid_end", 32'(if_m.valid), 32'd0);

        // Back-to-back words without a bubble.
        step(8'hA5, 1'b1, 1'b1);
        check("t3.q0", 32'(if_m.q), 32'hA);
        step(8'h3C, 1'b1, 1'b1);
        check("t3.q1", 32'(if_m.q), 32'h5);
        check("t3.level", 32'(if_m.level), 32'd1);
        step(8'h00, 1'b0, 1'b1);
        check("t3.q2", 32'(if_m.q), 32'h3);
        step(8'h00, 1'b0, 1'b1);
        check("t3.q3", 32'(if_m.q), 32'hC);
        step(8'h00, 1'b0, 1'b1);

        // Backpressure on the first chunk.
        step(8'hA5, 1'b1, 1'b0);
        repeat (3) step(8'hFF, 1'b0, 1'b0);
        check("t4.hold_q", 32'(if_m.q), 32'hA);
        step(8'h00, 1'b0, 1'b1);
        check("t4.after_q", 32'(if_m.q), 32'h5);
        step(8'h00, 1'b0, 1'b1);
        step(8'h00, 1'b0, 1'b1);

        // Overflow: six strobes into a stalled block, then drain.
        for (int i = 1; i <= 6; i++) step(8'(i * 8'h11), 1'b1, 1'b0);
        check("t5.level", 32'(if_m.level), 32'd4);
        check("t5.ready_in", 32'(if_m.ready_in), 32'd0);
        check("t5.overflow", 32'(if_m.overflow), 32'd1);
        for (int i = 0; i < 12; i++) step(8'h00, 1'b0, 1'b1);
        check("t5.ovf_sticky", 32'(if_m.overflow), 32'd1);

        // Asynchronous reset mid-word with two words queued.
        step(8'h12, 1'b1, 1'b0);
        step(8'h34, 1'b1, 1'b0);
        step(8'h56, 1'b1, 1'b0);
        step(8'h00, 1'b0, 1'b1);
        tb_ready = 1'b0;
        check("t6.level_pre", 32'(if_m.level), 32'd2);
        do_reset();
        step(8'h5A, 1'b1, 1'b1);
        check("t6.q0", 32'(if_m.q), 32'h5);
        step(8'h00, 1'b0, 1'b1);
        check("t6.q1", 32'(if_m.q), 32'hA);
        step(8'h00, 1'b0, 1'b1);

        // Randomised traffic with occasional resets.
        for (int c = 0; c < 3000; c++) begin
            if ($urandom_range(0, 399) == 0) begin
                do_reset();
            end else begin
                step(8'($urandom), ($urandom_range(0, 99) < 55), ($urandom_range(0, 99) < 65));
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
